// File: rtl/cfu_cfg_pkg.sv
// cfu_cfg_pkg: shared constants and types for the correctionfield-update
// configuration bank.
//   - register-space offsets of CTRL and ERRCNT as functions of NUM_REG
//   - CTRL bit positions, ERRCNT width
//   - read-response record layout and widths
package cfu_cfg_pkg;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 32;
  localparam int ERRCNT_W = 16;

  // CTRL: writing 1 to COMMIT requests a shadow->active transfer;
  // reads return the pending flag at PENDING.
  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_PENDING_BIT = 1;

  localparam int RESP_W = 1 + ADDR_W + 1 + DATA_W;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              fixed;
    logic [DATA_W-1:0] data;
  } resp_t;

  function automatic int ctrl_idx(input int num_reg);
    return num_reg;
  endfunction

  function automatic int errcnt_idx(input int num_reg);
    return num_reg + 1;
  endfunction

  // Width of a shadow-register index; at least one bit.
  function automatic int idx_w(input int num_reg);
    return (num_reg > 1) ? $clog2(num_reg) : 1;
  endfunction

endpackage

// File: rtl/cfu_shadow_commit.sv
// cfu_shadow_commit: shadow and active register arrays plus the commit
// handshake. Shadow registers are written by the bus; active registers load
// from all shadows at once when a commit is pending and the port is idle.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_wr_en           shadow write enable
//   iv_wr_idx         shadow register being written
//   iv_wdata          write data
//   i_commit_req      request a commit (ignored while one is pending)
//   i_port_idle       no frame in flight
//   ov_shadow         shadow registers, flattened
//   ov_active         active registers, flattened
//   o_pending         commit requested but not yet performed
//   o_cfg_update      one-cycle pulse, coincident with the active load
module cfu_shadow_commit
  import cfu_cfg_pkg::*;
#(
  parameter int                       NUM_REG = 4,
  parameter logic [32*NUM_REG-1:0]    RST_VAL = {NUM_REG{32'h0}}
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_wr_en,
  input  logic [idx_w(NUM_REG)-1:0]   iv_wr_idx,
  input  logic [DATA_W-1:0]           iv_wdata,
  input  logic                        i_commit_req,
  input  logic                        i_port_idle,
  output logic [DATA_W*NUM_REG-1:0]   ov_shadow,
  output logic [DATA_W*NUM_REG-1:0]   ov_active,
  output logic                        o_pending,
  output logic                        o_cfg_update
);

  localparam int IDX_W = idx_w(NUM_REG);

  logic [DATA_W-1:0] shadow_q [NUM_REG];
  logic [DATA_W-1:0] active_q [NUM_REG];
  logic              pending_q, pending_d;
  logic              cfg_update_q, cfg_update_d;
  logic              commit;

  assign commit = pending_q & i_port_idle;

  // A request arriving while pending is already set is absorbed; on the
  // commit cycle pending clears and is not re-armed by a same-cycle request.
  always_comb begin
    pending_d    = pending_q;
    cfg_update_d = 1'b0;
    if (commit) begin
      pending_d    = 1'b0;
      cfg_update_d = 1'b1;
    end else if (i_commit_req) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        shadow_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
        active_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end
      pending_q    <= 1'b0;
      cfg_update_q <= 1'b0;
    end else begin
      // Active loads the pre-edge shadow, so a same-cycle shadow write
      // stays in shadow only.
      for (int i = 0; i < NUM_REG; i++) begin
        if (i_wr_en && (iv_wr_idx == IDX_W'(i))) shadow_q[i] <= iv_wdata;
        if (commit) active_q[i] <= shadow_q[i];
      end
      pending_q    <= pending_d;
      cfg_update_q <= cfg_update_d;
    end
  end

  for (genvar g = 0; g < NUM_REG; g++) begin : g_flat
    assign ov_shadow[g*DATA_W +: DATA_W] = shadow_q[g];
    assign ov_active[g*DATA_W +: DATA_W] = active_q[g];
  end

  assign o_pending    = pending_q;
  assign o_cfg_update = cfg_update_q;

endmodule

// File: rtl/command_parse_and_encapsulate_cfu_bank.sv
// command_parse_and_encapsulate_cfu_bank: configuration register bank for
// the correctionfield-update path. Decodes fixed-space local-bus accesses
// into NUM_REG shadow registers, a CTRL register (commit request / pending)
// and an ERRCNT register (saturating malformed-access counter), and returns
// read responses one cycle later on the same bus encoding.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   iv_addr, i_addr_fixed          access address and fixed-space flag
//   iv_wdata, i_wr, i_rd           write data and single-cycle strobes
//   i_port_idle                    no frame in flight (commit allowed)
//   o_wr, ov_addr, o_addr_fixed,
//   ov_rdata                       read response
//   ov_cfg                         active registers, flattened
//   o_tsn_or_tte                   bit 0 of register 0
//   o_cfg_update                   pulse when active registers load
module command_parse_and_encapsulate_cfu_bank
  import cfu_cfg_pkg::*;
#(
  parameter int                    NUM_REG   = 4,
  parameter logic [18:0]           BASE_ADDR = 19'h0,
  parameter logic [32*NUM_REG-1:0] RST_VAL   = {NUM_REG{32'h0}}
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [18:0]              iv_addr,
  input  logic                     i_addr_fixed,
  input  logic [31:0]              iv_wdata,
  input  logic                     i_wr,
  input  logic                     i_rd,
  input  logic                     i_port_idle,
  output logic                     o_wr,
  output logic [18:0]              ov_addr,
  output logic                     o_addr_fixed,
  output logic [31:0]              ov_rdata,
  output logic [32*NUM_REG-1:0]    ov_cfg,
  output logic                     o_tsn_or_tte,
  output logic                     o_cfg_update
);

  localparam int                IDX_W    = idx_w(NUM_REG);
  localparam logic [ADDR_W-1:0] CTRL_OFS = ADDR_W'(ctrl_idx(NUM_REG));
  localparam logic [ADDR_W-1:0] ERR_OFS  = ADDR_W'(errcnt_idx(NUM_REG));

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (v == {ERRCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [ADDR_W-1:0]         idx;
  logic                      hit, sel_reg, sel_ctrl, sel_err;
  logic                      rd_ok, err_event, err_clr;
  logic [DATA_W*NUM_REG-1:0] shadow;
  logic                      pending;
  logic [DATA_W-1:0]         rdata_mux;
  logic [ERRCNT_W-1:0]       err_cnt_q, err_cnt_d;
  resp_t                     resp_q, resp_d;

  // Addresses below BASE_ADDR wrap to a large offset and miss.
  assign idx      = iv_addr - BASE_ADDR;
  assign hit      = i_addr_fixed & (idx <= ERR_OFS);
  assign sel_reg  = hit & (idx < CTRL_OFS);
  assign sel_ctrl = hit & (idx == CTRL_OFS);
  assign sel_err  = hit & (idx == ERR_OFS);

  // Simultaneous write+read: the write proceeds, the read is dropped.
  assign rd_ok     = i_rd & ~i_wr & hit;
  assign err_event = (i_wr & i_rd) | ((i_wr | i_rd) & ~hit);
  assign err_clr   = i_wr & sel_err;

  cfu_shadow_commit #(
    .NUM_REG (NUM_REG),
    .RST_VAL (RST_VAL)
  ) u_shadow_commit (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_wr_en      (i_wr & sel_reg),
    .iv_wr_idx    (idx[IDX_W-1:0]),
    .iv_wdata     (iv_wdata),
    .i_commit_req (i_wr & sel_ctrl & iv_wdata[CTRL_COMMIT_BIT]),
    .i_port_idle  (i_port_idle),
    .ov_shadow    (shadow),
    .ov_active    (ov_cfg),
    .o_pending    (pending),
    .o_cfg_update (o_cfg_update)
  );

  always_comb begin
    rdata_mux = '0;
    if (sel_reg) begin
      for (int i = 0; i < NUM_REG; i++)
        if (idx == ADDR_W'(i)) rdata_mux = shadow[i*DATA_W +: DATA_W];
    end else if (sel_ctrl) begin
      rdata_mux[CTRL_PENDING_BIT] = pending;
    end else if (sel_err) begin
      rdata_mux[ERRCNT_W-1:0] = err_cnt_q;
    end
  end

  always_comb begin
    resp_d = '0;
    if (rd_ok) begin
      resp_d.wr    = 1'b1;
      resp_d.addr  = iv_addr;
      resp_d.fixed = 1'b1;
      resp_d.data  = rdata_mux;
    end
  end

  // A clear beats an error event in the same cycle.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)        err_cnt_d = '0;
    else if (err_event) err_cnt_d = sat_inc(err_cnt_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resp_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      resp_q    <= resp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_wr         = resp_q.wr;
  assign ov_addr      = resp_q.addr;
  assign o_addr_fixed = resp_q.fixed;
  assign ov_rdata     = resp_q.data;
  assign o_tsn_or_tte = ov_cfg[0];

endmodule

// File: tb/tb_command_parse_and_encapsulate_cfu_bank.sv
module tb_command_parse_and_encapsulate_cfu_bank;

  localparam int           NUM_REG = 4;
  localparam logic [18:0]  BASE    = 19'h40;
  localparam logic [127:0] RSTV    = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h1};
  localparam logic [18:0]  A_CTRL  = BASE + 19'd4;
  localparam logic [18:0]  A_ERR   = BASE + 19'd5;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [18:0]  iv_addr;
  logic         i_addr_fixed;
  logic [31:0]  iv_wdata;
  logic         i_wr, i_rd, i_port_idle;
  logic         o_wr, o_addr_fixed, o_tsn_or_tte, o_cfg_update;
  logic [18:0]  ov_addr;
  logic [31:0]  ov_rdata;
  logic [127:0] ov_cfg;

  int n_tests = 0;
  int n_fail  = 0;

  command_parse_and_encapsulate_cfu_bank #(
    .NUM_REG   (NUM_REG),
    .BASE_ADDR (BASE),
    .RST_VAL   (RSTV)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .iv_addr      (iv_addr),
    .i_addr_fixed (i_addr_fixed),
    .iv_wdata     (iv_wdata),
    .i_wr         (i_wr),
    .i_rd         (i_rd),
    .i_port_idle  (i_port_idle),
    .o_wr         (o_wr),
    .ov_addr      (ov_addr),
    .o_addr_fixed (o_addr_fixed),
    .ov_rdata     (ov_rdata),
    .ov_cfg       (ov_cfg),
    .o_tsn_or_tte (o_tsn_or_tte),
    .o_cfg_update (o_cfg_update)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    i_wr = 0; i_rd = 0; i_addr_fixed = 0; iv_addr = '0; iv_wdata = '0;
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // One bus cycle; outputs are sampled 1ns after the edge that consumed it.
  task automatic acc(input logic wr, input logic rd, input logic fixed,
                     input logic [18:0] addr, input logic [31:0] data);
    i_wr = wr; i_rd = rd; i_addr_fixed = fixed; iv_addr = addr; iv_wdata = data;
    tick();
    clr_in();
  endtask

  task automatic wr_reg(input logic [18:0] addr, input logic [31:0] data);
    acc(1, 0, 1, addr, data);
  endtask

  task automatic rd_chk(input string tag, input logic [18:0] addr, input logic [31:0] exp);
    acc(0, 1, 1, addr, '0);
    chk({tag, "_vld"},  {63'd0, o_wr}, 64'd1);
    chk({tag, "_addr"}, {45'd0, ov_addr}, {45'd0, addr});
    chk({tag, "_fix"},  {63'd0, o_addr_fixed}, 64'd1);
    chk({tag, "_data"}, {32'd0, ov_rdata}, {32'd0, exp});
  endtask

  task automatic no_resp(input string tag);
    chk({tag, "_vld"},  {63'd0, o_wr}, 64'd0);
    chk({tag, "_resp"}, {12'd0, ov_addr, o_addr_fixed, ov_rdata}, 64'd0);
  endtask

  initial begin
    clr_in();
    i_port_idle = 0;
    i_rst_n = 0;
    repeat (3) @(posedge i_clk);
    #1;
    // Reset state
    chk("rst_cfg0", {32'd0, ov_cfg[31:0]}, 64'h1);
    chk("rst_cfg2", {32'd0, ov_cfg[95:64]}, 64'hDEAD_BEEF);
    chk("rst_tsn",  {63'd0, o_tsn_or_tte}, 64'd1);
    chk("rst_upd",  {63'd0, o_cfg_update}, 64'd0);
    no_resp("rst");
    i_rst_n = 1;
    tick();
    rd_chk("ctrl0", A_CTRL, 32'h0);
    tick();
    no_resp("one_cycle");
    rd_chk("err0", A_ERR, 32'h0);

    // Shadow write / read-back, active untouched
    wr_reg(BASE + 19'd1, 32'hA5A5_0001);
    rd_chk("reg1", BASE + 19'd1, 32'hA5A5_0001);
    chk("act1_hold", {32'd0, ov_cfg[63:32]}, 64'h0);
    rd_chk("reg2", BASE + 19'd2, 32'hDEAD_BEEF);

    // Commit held off by a busy port
    wr_reg(A_CTRL, 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("wait_upd", {63'd0, o_cfg_update}, 64'd0);
    end
    rd_chk("ctrl_pend", A_CTRL, 32'h2);
    chk("act1_wait", {32'd0, ov_cfg[63:32]}, 64'h0);
    i_port_idle = 1;
    tick();
    chk("commit_upd", {63'd0, o_cfg_update}, 64'd1);
    chk("commit_act1", {32'd0, ov_cfg[63:32]}, 64'hA5A5_0001);
    tick();
    chk("upd_pulse", {63'd0, o_cfg_update}, 64'd0);
    i_port_idle = 0;
    rd_chk("ctrl_clr", A_CTRL, 32'h0);

    // Shadow write on the commit cycle
    wr_reg(A_CTRL, 32'h1);
    i_port_idle = 1;
    wr_reg(BASE, 32'h0);
    chk("cc_upd",  {63'd0, o_cfg_update}, 64'd1);
    chk("cc_act0", {32'd0, ov_cfg[31:0]}, 64'h1);
    chk("cc_tsn",  {63'd0, o_tsn_or_tte}, 64'd1);
    rd_chk("cc_sh0", BASE, 32'h0);
    chk("cc_noupd", {63'd0, o_cfg_update}, 64'd0);
    rd_chk("cc_ctrl", A_CTRL, 32'h0);
    chk("cc_tsn2", {63'd0, o_tsn_or_tte}, 64'd1);
    i_port_idle = 0;

    // Malformed accesses
    acc(0, 1, 1, BASE + 19'd6, '0);
    no_resp("miss_hi");
    acc(1, 0, 0, BASE + 19'd1, 32'hFFFF_FFFF);
    no_resp("miss_nofix");
    acc(1, 1, 1, BASE + 19'd2, 32'h1234_5678);
    no_resp("wr_rd");
    rd_chk("err3", A_ERR, 32'h3);
    rd_chk("reg1_keep", BASE + 19'd1, 32'hA5A5_0001);
    rd_chk("reg2_wr", BASE + 19'd2, 32'h1234_5678);
    acc(0, 1, 1, BASE - 19'd1, '0);
    no_resp("miss_lo");
    rd_chk("err4", A_ERR, 32'h4);
    wr_reg(A_ERR, 32'h0);
    rd_chk("err_clr", A_ERR, 32'h0);
    acc(0, 1, 0, BASE, '0);
    rd_chk("err1", A_ERR, 32'h1);
    acc(1, 1, 1, A_ERR, 32'hFFFF_FFFF);
    rd_chk("clr_wins", A_ERR, 32'h0);

    // Saturation
    i_rd = 1; i_addr_fixed = 0; iv_addr = BASE;
    repeat (65540) @(posedge i_clk);
    #1;
    clr_in();
    rd_chk("err_sat", A_ERR, 32'h0000_FFFF);
    acc(0, 1, 0, BASE, '0);
    rd_chk("err_sat2", A_ERR, 32'h0000_FFFF);

    // Reset mid-operation
    wr_reg(A_CTRL, 32'h1);
    i_rd = 1; i_addr_fixed = 1; iv_addr = BASE + 19'd1;
    #2 i_rst_n = 0;
    @(posedge i_clk); #1;
    clr_in();
    no_resp("mid_rst");
    chk("mid_act1", {32'd0, ov_cfg[63:32]}, 64'h0);
    chk("mid_act0", {32'd0, ov_cfg[31:0]}, 64'h1);
    i_rst_n = 1;
    i_port_idle = 1;
    tick();
    chk("mid_noupd", {63'd0, o_cfg_update}, 64'd0);
    rd_chk("mid_reg1", BASE + 19'd1, 32'h0);
    rd_chk("mid_ctrl", A_CTRL, 32'h0);
    rd_chk("mid_err", A_ERR, 32'h0);
    chk("mid_noupd2", {63'd0, o_cfg_update}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/command_parse_and_encapsulate_cfu_bank.md
# command_parse_and_encapsulate_cfu_bank

Parametrised configuration register bank for the correctionfield-update path of the 1G MAC. It decodes fixed-address local-bus writes and reads into NUM_REG 32-bit shadow registers, transfers them atomically to active registers only when the port is idle between frames, and returns read responses on the same bus encoding. It also counts malformed accesses. It replaces the single-bit tsn_or_tte register: register 0 bit 0 keeps that meaning.

## Interface
- NUM_REG, 4: number of configuration registers, 1..16
- BASE_ADDR, 19'h0: fixed address of register 0
- RST_VAL, {NUM_REG{32'h0}}: flattened reset value of every register, reg i at bits [32i+31:32i]
- i_clk  in  1  single clock
- i_rst_n  in  1  asynchronous, active-low reset
- iv_addr  in  19  access address
- i_addr_fixed  in  1  address is in fixed (register) space
- iv_wdata  in  32  write data
- i_wr  in  1  write strobe, one cycle per access
- i_rd  in  1  read strobe, one cycle per access
- i_port_idle  in  1  high when no frame is in flight through the cfu datapath
- o_wr  out  1  read-response valid
- ov_addr  out  19  read-response address
- o_addr_fixed  out  1  read-response fixed flag
- ov_rdata  out  32  read-response data
- ov_cfg  out  32*NUM_REG  active registers, flattened
- o_tsn_or_tte  out  1  equals ov_cfg[0]
- o_cfg_update  out  1  one-cycle pulse when the active registers are loaded

## Operation
- Decode:
  - An access hits only when i_addr_fixed=1 and 0 <= idx <= NUM_REG+1, where idx = iv_addr - BASE_ADDR. Any other access is a miss.
  - idx < NUM_REG selects shadow register idx.
  - idx = NUM_REG selects CTRL.
  - idx = NUM_REG+1 selects ERRCNT.
- Write to a shadow register: the shadow register takes iv_wdata. Active registers are unchanged.
- Write to CTRL with bit0=1 sets pending. Any other CTRL write has no effect, including a write while pending is already set.
- Write to ERRCNT clears the counter regardless of data.
- Read responses:
  - Shadow register: {o_wr,ov_addr,o_addr_fixed,ov_rdata} = {1, iv_addr, 1, shadow[idx]}.
  - CTRL: returns {30'b0, pending, 1'b0}.
  - ERRCNT: returns {16'b0, err_cnt}.
- Commit:
  - When pending=1 and i_port_idle=1, all active registers load from shadow in the same cycle.
  - On that cycle o_cfg_update pulses and pending clears.
  - If i_port_idle stays low, pending holds indefinitely.
- Error counter:
  - 16-bit, saturating at 16'hFFFF.
  - Increments by 1 on a read miss, a write miss, or i_wr and i_rd in the same cycle.
- Reset values:
  - Outputs: o_wr, ov_addr, o_addr_fixed, ov_rdata, and o_cfg_update are 0.
  - Shadow and active registers take RST_VAL, so ov_cfg=RST_VAL and o_tsn_or_tte=RST_VAL[0].
  - pending=0, err_cnt=0.

## Timing
- Read latency is 1 cycle: the response appears on the cycle after i_rd and lasts exactly 1 cycle.
- On a miss, o_wr stays 0 and all response fields are 0.
- Response fields are 0 whenever o_wr=0.
- A write takes effect on the next clock edge, and a read in the following cycle returns the new shadow value.
- The earliest commit is 1 cycle after the CTRL write, because pending is registered.
  - ov_cfg changes on the cycle o_cfg_update is high.
- i_wr and i_rd together: the write executes, the read is dropped with no response, and err_cnt increments.
- A shadow write on the commit cycle: active takes the pre-write shadow value, and the new value stays pending in shadow only. pending is not re-set.
- An ERRCNT clear and an error event on the same cycle: the clear wins, and the counter ends at 0.
- Reset asserted mid-operation: all state returns to reset values immediately. A response in flight is lost, and pending is discarded.
- The bank does not back-pressure: one access per cycle is sustained.

## Structure
- Shared package cfu_cfg_pkg holds:
  - CTRL/ERRCNT offset functions of NUM_REG
  - CTRL bit positions
  - the ERRCNT width (16)
  - the response record width constants
- Sub-module cfu_shadow_commit: one instance holding the shadow and active arrays, pending, and the commit handshake. The top module holds the address decode, the read mux/response register and the error counter.

## Test plan
- Reset with RST_VAL reg0=32'h1 -> ov_cfg[31:0]=1, o_tsn_or_tte=1, o_wr=0, and a CTRL read returns 0.
- Write reg1=32'hA5A5_0001, then read reg1 -> next-cycle response {o_wr=1, ov_addr=BASE+1, ov_rdata=32'hA5A5_0001}, and ov_cfg reg1 is unchanged.
- Write CTRL=1 with i_port_idle=0 for 20 cycles, then raise idle -> CTRL reads 32'h2 while waiting, o_cfg_update pulses once on the first idle cycle, ov_cfg reg1=32'hA5A5_0001, and CTRL then reads 0.
- Shadow write reg0=0 on the exact commit cycle -> active reg0 keeps the pre-write value, shadow reads 0, and o_tsn_or_tte is unchanged.
- Read at BASE+NUM_REG+2, then a write with i_addr_fixed=0, then i_wr&i_rd together -> no responses, and ERRCNT reads 3. A write to ERRCNT then makes it read 0.
- Force 65540 miss events -> ERRCNT reads 32'h0000_FFFF.
